// File: rtl/acc_cluster_ctrl.sv
// acc_cluster_ctrl: accelerator lane hub. Round-robin arbitration of N_CH lanes
// onto memory port A, start fan-out, finish merge, run-cycle counter and watchdog.
module acc_cluster_ctrl #(
    parameter int N_CH    = 4,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [N_CH-1:0]          ch_req,
    input  logic [N_CH-1:0]          ch_we,
    input  logic [N_CH*ADDR_W-1:0]   ch_addr,
    input  logic [N_CH*DATA_W-1:0]   ch_dw,
    output logic [N_CH-1:0]          ch_gnt,
    output logic [N_CH-1:0]          ch_rvalid,
    output logic [DATA_W-1:0]        ch_dr,
    output logic [N_CH-1:0]          ch_start,
    input  logic [N_CH-1:0]          ch_finish,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_dw,
    input  logic [DATA_W-1:0]        mem_dr,
    output logic                     finish,
    output logic                     err,
    output logic [CNT_W-1:0]         cycles
);

    localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rr_q, rr_d;
    logic [PTR_W-1:0]   win;
    logic [PTR_W-1:0]   idx_p;
    int unsigned        idx;
    logic               found;
    logic [N_CH-1:0]    done_q;
    logic [N_CH-1:0]    rvalid_q;
    logic               start_q;
    logic               start_rise;
    logic [CNT_W-1:0]   cycles_q;

    assign start_rise = start & ~start_q;
    assign ch_rvalid  = rvalid_q;
    assign ch_dr      = mem_dr;
    assign cycles     = cycles_q;

    // Cyclic search for the first requester at or after the pointer; the winner drives port A.
    always_comb begin
        found    = 1'b0;
        win      = '0;
        idx      = 0;
        idx_p    = '0;
        rr_d     = rr_q;
        ch_gnt   = '0;
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_dw   = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            idx   = (32'(rr_q) + k) % N_CH;
            idx_p = PTR_W'(idx);
            if (!found && ch_req[idx_p]) begin
                found = 1'b1;
                win   = idx_p;
            end
        end
        // No grant is issued while reset is asserted.
        if (found && rst) begin
            ch_gnt[win] = 1'b1;
            mem_en      = 1'b1;
            mem_we      = ch_we[win];
            mem_addr    = ch_addr[win*ADDR_W +: ADDR_W];
            mem_dw      = ch_dw[win*DATA_W +: DATA_W];
            rr_d        = (win == PTR_W'(N_CH - 1)) ? '0 : win + PTR_W'(1);
        end
    end

    // Pointer, start-edge register and one-cycle read-valid pipeline.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_q     <= '0;
            start_q  <= 1'b0;
            rvalid_q <= '0;
        end else begin
            rr_q     <= rr_d;
            start_q  <= start;
            rvalid_q <= (mem_en && !mem_we) ? ch_gnt : '0;
        end
    end

    // Sequencer next-state and state-decoded outputs.
    always_comb begin
        state_d  = state_q;
        ch_start = '0;
        finish   = 1'b0;
        err      = 1'b0;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start_rise) state_d = RUN;
            end
            RUN: begin
                // Completion is checked first so it wins over a simultaneous timeout.
                if (&done_q) begin
                    state_d = DONE;
                end else if (TIMEOUT != 0 && cycles_q == TO_LAST) begin
                    state_d = ERR;
                end
            end
            default: state_d = IDLE;
        endcase
        ch_start = (state_q == RUN) ? '1 : '0;
        finish   = (state_q == DONE);
        err      = (state_q == ERR);
    end

    // Sequencer state, sticky done flags and saturating run-cycle counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            done_q   <= '0;
            cycles_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q != RUN && state_d == RUN) begin
                done_q   <= '0;
                cycles_q <= '0;
            end else if (state_q == RUN) begin
                done_q <= done_q | ch_finish;
                if (cycles_q != '1) cycles_q <= cycles_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_acc_cluster_ctrl.sv
// Self-checking bench for acc_cluster_ctrl (N_CH=4, TIMEOUT=100).
module tb_acc_cluster_ctrl;

    localparam int N_CH    = 4;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 32;
    localparam int CNT_W   = 32;
    localparam int TIMEOUT = 100;

    logic                   clk;
    logic                   rst;
    logic                   start;
    logic [N_CH-1:0]        ch_req;
    logic [N_CH-1:0]        ch_we;
    logic [N_CH*ADDR_W-1:0] ch_addr;
    logic [N_CH*DATA_W-1:0] ch_dw;
    logic [N_CH-1:0]        ch_gnt;
    logic [N_CH-1:0]        ch_rvalid;
    logic [DATA_W-1:0]      ch_dr;
    logic [N_CH-1:0]        ch_start;
    logic [N_CH-1:0]        ch_finish;
    logic                   mem_en;
    logic                   mem_we;
    logic [ADDR_W-1:0]      mem_addr;
    logic [DATA_W-1:0]      mem_dw;
    logic [DATA_W-1:0]      mem_dr;
    logic                   finish;
    logic                   err;
    logic [CNT_W-1:0]       cycles;

    int n_cmp = 0;
    int n_bad = 0;

    int                gnt_q[$];
    int                rd_lane_q[$];
    logic [DATA_W-1:0] rd_data_q[$];
    logic [CNT_W-1:0]  cyc_q[$];

    logic [DATA_W-1:0] mem [0:255];

    acc_cluster_ctrl #(
        .N_CH   (N_CH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .ch_req   (ch_req),
        .ch_we    (ch_we),
        .ch_addr  (ch_addr),
        .ch_dw    (ch_dw),
        .ch_gnt   (ch_gnt),
        .ch_rvalid(ch_rvalid),
        .ch_dr    (ch_dr),
        .ch_start (ch_start),
        .ch_finish(ch_finish),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_dw   (mem_dw),
        .mem_dr   (mem_dr),
        .finish   (finish),
        .err      (err),
        .cycles   (cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Port A memory: synchronous read-first RAM.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[7:0]] <= mem_dw;
            mem_dr <= mem[mem_addr[7:0]];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic we, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d);
        ch_we[i] = we;
        ch_addr[i*ADDR_W +: ADDR_W] = a;
        ch_dw[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; ch_finish = '0; ch_req = '1; ch_we = '0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_cmp++;
            if (ch_gnt !== 4'b0000 || mem_en !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_gnt[%0d]: ch_gnt=%b mem_en=%b, expected 0000/0", k, ch_gnt, mem_en);
            end
            tick();
        end
        @(negedge clk);
        n_cmp++;
        if (finish !== 1'b0 || err !== 1'b0 || cycles !== '0 || ch_start !== '0 || ch_rvalid !== '0) begin
            n_bad++;
            $display("FAIL reset_outs: finish=%b err=%b cycles=%0d ch_start=%b ch_rvalid=%b, expected all 0",
                     finish, err, cycles, ch_start, ch_rvalid);
        end
        tick();
        rst = 1'b1; ch_req = '0;
    endtask

    task automatic test_round_robin();
        int lane;
        for (int i = 0; i < N_CH; i++) set_lane(i, 1'b1, ADDR_W'(16 + i), DATA_W'(32'hA000_0000 + i));
        ch_req = 4'b1111;
        for (int k = 0; k < 8; k++) gnt_q.push_back(k % 4);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            lane = gnt_q.pop_front();
            n_cmp++;
            if (ch_gnt !== 4'(1 << lane) || mem_addr !== ADDR_W'(16 + lane) || ch_rvalid !== '0) begin
                n_bad++;
                $display("FAIL rr_all[%0d]: gnt=%b addr=%h rvalid=%b, expected gnt=%b addr=%h rvalid=0000",
                         k, ch_gnt, mem_addr, ch_rvalid, 4'(1 << lane), ADDR_W'(16 + lane));
            end
            tick();
        end
        ch_req = 4'b1010;
        for (int k = 0; k < 4; k++) gnt_q.push_back((k % 2 == 0) ? 1 : 3);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            lane = gnt_q.pop_front();
            n_cmp++;
            if (ch_gnt !== 4'(1 << lane) || mem_dw !== DATA_W'(32'hA000_0000 + lane)) begin
                n_bad++;
                $display("FAIL rr_1010[%0d]: gnt=%b dw=%h, expected gnt=%b dw=%h",
                         k, ch_gnt, mem_dw, 4'(1 << lane), DATA_W'(32'hA000_0000 + lane));
            end
            tick();
        end
        ch_req = '0;
        @(negedge clk);
        n_cmp++;
        if (ch_gnt !== '0 || mem_en !== 1'b0) begin
            n_bad++;
            $display("FAIL rr_idle: gnt=%b mem_en=%b, expected 0000/0", ch_gnt, mem_en);
        end
        tick();
    endtask

    task automatic test_read_latency();
        int lane;
        logic [DATA_W-1:0] d;
        set_lane(0, 1'b1, 16'h0123, 32'hDEADBEEF);
        ch_req = 4'b0001;
        @(negedge clk);
        n_cmp++;
        if (ch_gnt !== 4'b0001 || mem_we !== 1'b1) begin
            n_bad++;
            $display("FAIL rd_prewrite: gnt=%b we=%b, expected 0001/1", ch_gnt, mem_we);
        end
        tick();
        set_lane(2, 1'b0, 16'h0123, '0);
        ch_req = 4'b0100;
        rd_lane_q.push_back(2);
        rd_data_q.push_back(32'hDEADBEEF);
        @(negedge clk);
        n_cmp++;
        if (ch_gnt !== 4'b0100 || mem_we !== 1'b0 || mem_addr !== 16'h0123 || ch_rvalid !== '0) begin
            n_bad++;
            $display("FAIL rd_grant: gnt=%b we=%b addr=%h rvalid=%b, expected 0100/0/0123/0000",
                     ch_gnt, mem_we, mem_addr, ch_rvalid);
        end
        tick();
        ch_req = '0;
        @(negedge clk);
        lane = rd_lane_q.pop_front();
        d = rd_data_q.pop_front();
        n_cmp++;
        if (ch_rvalid !== 4'(1 << lane) || ch_dr !== d) begin
            n_bad++;
            $display("FAIL rd_data: rvalid=%b dr=%h, expected %b/%h", ch_rvalid, ch_dr, 4'(1 << lane), d);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int lane;
        logic [DATA_W-1:0] d;
        logic [N_CH-1:0] g;
        set_lane(0, 1'b0, 16'h0010, '0);
        set_lane(1, 1'b0, 16'h0011, '0);
        ch_req = 4'b0011;
        gnt_q.push_back(0); gnt_q.push_back(1);
        rd_lane_q.push_back(0); rd_data_q.push_back(32'hA000_0000);
        rd_lane_q.push_back(1); rd_data_q.push_back(32'hA000_0001);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (gnt_q.size() > 0) begin
                lane = gnt_q.pop_front();
                n_cmp++;
                if (ch_gnt !== 4'(1 << lane)) begin
                    n_bad++;
                    $display("FAIL b2b_gnt[%0d]: gnt=%b, expected %b", c, ch_gnt, 4'(1 << lane));
                end
            end
            if (ch_rvalid !== '0) begin
                n_cmp++;
                if (rd_lane_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL b2b_extra[%0d]: rvalid=%b, expected 0000", c, ch_rvalid);
                end else begin
                    lane = rd_lane_q.pop_front();
                    d = rd_data_q.pop_front();
                    if (ch_rvalid !== 4'(1 << lane) || ch_dr !== d) begin
                        n_bad++;
                        $display("FAIL b2b_rd[%0d]: rvalid=%b dr=%h, expected %b/%h",
                                 c, ch_rvalid, ch_dr, 4'(1 << lane), d);
                    end
                end
            end
            g = ch_gnt;
            tick();
            ch_req = ch_req & ~g;
        end
        n_cmp++;
        if (rd_lane_q.size() != 0) begin
            n_bad++;
            $display("FAIL b2b_missing: %0d reads outstanding, expected 0", rd_lane_q.size());
        end
        rd_lane_q.delete(); rd_data_q.delete(); gnt_q.delete();
        ch_req = '0;
    endtask

    task automatic test_run_finish();
        int fin_at[4] = '{10, 25, 3, 40};
        int got = -1;
        ch_finish = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc_q.push_back(41);
        for (int r = 1; r <= 80; r++) begin
            for (int i = 0; i < N_CH; i++) if (r >= fin_at[i]) ch_finish[i] = 1'b1;
            @(negedge clk);
            if (r == 1) begin
                n_cmp++;
                if (ch_start !== 4'b1111 || cycles !== '0 || finish !== 1'b0) begin
                    n_bad++;
                    $display("FAIL run_enter: ch_start=%b cycles=%0d finish=%b, expected 1111/0/0",
                             ch_start, cycles, finish);
                end
            end
            if (finish === 1'b1) begin
                got = r;
                break;
            end
            tick();
        end
        n_cmp++;
        if (got != 42 || cycles !== cyc_q.pop_front() || ch_start !== '0 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL run_done: finish at %0d cycles=%0d ch_start=%b err=%b, expected 42/41/0000/0",
                     got, cycles, ch_start, err);
        end
        tick(); tick();
        @(negedge clk);
        n_cmp++;
        if (cycles !== 41 || finish !== 1'b1) begin
            n_bad++;
            $display("FAIL run_frozen: cycles=%0d finish=%b, expected 41/1", cycles, finish);
        end
        tick();
        ch_finish = '0;
    endtask

    task automatic test_watchdog();
        int got = -1;
        ch_finish = 4'b0111;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n <= 150; n++) begin
            @(negedge clk);
            if (err === 1'b1) begin
                got = n;
                break;
            end
            tick();
        end
        n_cmp++;
        if (got != 101 || cycles !== 100 || ch_start !== '0 || finish !== 1'b0) begin
            n_bad++;
            $display("FAIL wdog_err: err at %0d cycles=%0d ch_start=%b finish=%b, expected 101/100/0000/0",
                     got, cycles, ch_start, finish);
        end
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (err !== 1'b0 || ch_start !== 4'b1111 || cycles !== '0) begin
            n_bad++;
            $display("FAIL wdog_restart: err=%b ch_start=%b cycles=%0d, expected 0/1111/0", err, ch_start, cycles);
        end
        tick();
        ch_finish = 4'b1111;
        tick(); tick();
        @(negedge clk);
        n_cmp++;
        if (finish !== 1'b1 || cycles !== 3) begin
            n_bad++;
            $display("FAIL wdog_complete: finish=%b cycles=%0d, expected 1/3", finish, cycles);
        end
        tick();
        ch_finish = '0;
    endtask

    task automatic test_held_start();
        int run = 0;
        start = 1'b1;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (ch_start === 4'b1111) run++;
            tick();
        end
        @(negedge clk);
        n_cmp++;
        if (run != 100 || err !== 1'b1 || cycles !== 100) begin
            n_bad++;
            $display("FAIL held_start: run cycles=%0d err=%b cycles=%0d, expected 100/1/100", run, err, cycles);
        end
        tick();
        start = 1'b0;
        tick();
    endtask

    task automatic test_coincide();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (98) tick();
        ch_finish = '1;
        @(negedge clk);
        n_cmp++;
        if (cycles !== 98 || ch_start !== 4'b1111) begin
            n_bad++;
            $display("FAIL coin_pre: cycles=%0d ch_start=%b, expected 98/1111", cycles, ch_start);
        end
        for (int n = 1; n <= 10; n++) begin
            tick();
            @(negedge clk);
            if (finish === 1'b1 || err === 1'b1) break;
        end
        n_cmp++;
        if (finish !== 1'b1 || err !== 1'b0 || cycles !== 100) begin
            n_bad++;
            $display("FAIL coin_done: finish=%b err=%b cycles=%0d, expected 1/0/100", finish, err, cycles);
        end
        tick();
        ch_finish = '0;
    endtask

    task automatic test_reset_midrun();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        set_lane(2, 1'b1, 16'h0020, 32'h0000_0055);
        ch_req = 4'b0100;
        tick();
        rst = 1'b0;
        set_lane(1, 1'b0, 16'h0010, '0);
        ch_req = 4'b0010;
        @(negedge clk);
        n_cmp++;
        if (ch_gnt !== '0 || mem_en !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_rst_gnt: gnt=%b mem_en=%b, expected 0000/0", ch_gnt, mem_en);
        end
        tick();
        rst = 1'b1;
        ch_req = '0;
        @(negedge clk);
        n_cmp++;
        if (ch_rvalid !== '0 || ch_start !== '0 || cycles !== '0 || finish !== 1'b0 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_rst_outs: rvalid=%b ch_start=%b cycles=%0d finish=%b err=%b, expected all 0",
                     ch_rvalid, ch_start, cycles, finish, err);
        end
        tick();
        for (int i = 0; i < N_CH; i++) set_lane(i, 1'b1, ADDR_W'(16 + i), DATA_W'(32'hA000_0000 + i));
        ch_req = 4'b1111;
        @(negedge clk);
        n_cmp++;
        if (ch_gnt !== 4'b0001) begin
            n_bad++;
            $display("FAIL mid_rst_ptr: gnt=%b, expected 0001", ch_gnt);
        end
        tick();
        ch_req = '0;
        repeat (3) tick();
        @(negedge clk);
        n_cmp++;
        if (cycles !== '0 || ch_start !== '0) begin
            n_bad++;
            $display("FAIL mid_rst_idle: cycles=%0d ch_start=%b, expected 0/0000", cycles, ch_start);
        end
        tick();
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = '0;
        mem_dr = '0;
        ch_addr = '0;
        ch_dw = '0;
        test_reset();
        test_round_robin();
        test_read_latency();
        test_back_to_back();
        test_run_finish();
        test_watchdog();
        test_held_start();
        test_coincide();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
